// File: rtl/word_burst_responder.sv
// word_burst_responder
//   Turns word-granular core data-port requests into 256-bit line transactions
//   on a 4 x 64-bit burst memory port. Reads fetch the line and return one word.
//   Writes fetch the line, merge the enabled bytes, then write the whole line back.
//   Optional feature macro: LINE_BUF_EN keeps the last completed line with a
//   valid bit and tag, so a hit skips the read burst (writes stay write-through).
module word_burst_responder #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [3:0]        data_mbe,
  input  logic [ADDR_W-1:0] data_mem_address,
  input  logic [31:0]       data_mem_wdata,
  output logic              data_mem_resp,
  output logic [31:0]       data_mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int LINE_W = BEATS * BEAT_W;
  localparam int WORDS  = LINE_W / 32;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WIDX_W = $clog2(WORDS);
  localparam int BCNT_W = $clog2(BEATS);
  localparam int TAG_W  = ADDR_W - OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    MERGE,
    WB_BURST,
    RESP
  } state_t;

  state_t              state_reg;
  logic [BCNT_W-1:0]   beat_cnt_reg;
  logic [LINE_W-1:0]   line_reg;
  logic [LINE_W-1:0]   merged_line;
  logic [WIDX_W-1:0]   word_idx_reg;
  logic [31:0]         wdata_reg;
  logic [3:0]          mbe_reg;
  logic                is_write_reg;
  logic                last_beat;
  logic                unused_addr_bits;

  // Byte offset within a word never selects anything: the port is word-granular.
  assign unused_addr_bits = ^data_mem_address[1:0];

  assign last_beat = (beat_cnt_reg == BCNT_W'(BEATS - 1));

`ifdef LINE_BUF_EN
  logic             valid_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             buf_hit;

  assign buf_hit = valid_reg && (tag_reg == data_mem_address[ADDR_W-1:OFF_W]);
`endif

  // Byte-lane merge of the latched write word into the fetched line.
  for (genvar gi = 0; gi < LINE_W / 8; gi++) begin : g_merge
    assign merged_line[gi*8 +: 8] =
      ((word_idx_reg == WIDX_W'(gi / 4)) && mbe_reg[gi % 4]) ? wdata_reg[(gi % 4)*8 +: 8]
                                                             : line_reg[gi*8 +: 8];
  end

  // Outgoing write beat and returned word are selected straight from the line buffer.
  assign pmem_wdata     = pmem_write    ? line_reg[beat_cnt_reg*BEAT_W +: BEAT_W] : '0;
  assign data_mem_rdata = data_mem_resp ? line_reg[word_idx_reg*32 +: 32]        : '0;

  // Line buffer: captures read beats and applies the merge; contents need no reset.
  always_ff @(posedge clk) begin
    if (state_reg == RD_BURST && pmem_resp) begin
      line_reg[beat_cnt_reg*BEAT_W +: BEAT_W] <= pmem_rdata;
    end else if (state_reg == MERGE) begin
      line_reg <= merged_line;
    end
  end

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      beat_cnt_reg  <= '0;
      pmem_read     <= 1'b0;
      pmem_write    <= 1'b0;
      pmem_address  <= '0;
      data_mem_resp <= 1'b0;
      word_idx_reg  <= '0;
      wdata_reg     <= '0;
      mbe_reg       <= '0;
      is_write_reg  <= 1'b0;
`ifdef LINE_BUF_EN
      valid_reg     <= 1'b0;
      tag_reg       <= '0;
`endif
    end else begin
      data_mem_resp <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (data_read || data_write) begin
            word_idx_reg <= data_mem_address[OFF_W-1:2];
            wdata_reg    <= data_mem_wdata;
            mbe_reg      <= data_mbe;
            is_write_reg <= data_write;
            pmem_address <= {data_mem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            beat_cnt_reg <= '0;
`ifdef LINE_BUF_EN
            if (buf_hit) begin
              if (data_write) begin
                state_reg <= MERGE;
              end else begin
                state_reg     <= RESP;
                data_mem_resp <= 1'b1;
              end
            end else begin
              state_reg <= RD_BURST;
              pmem_read <= 1'b1;
            end
`else
            state_reg <= RD_BURST;
            pmem_read <= 1'b1;
`endif
          end
        end
        RD_BURST: begin
          if (pmem_resp) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (last_beat) begin
              pmem_read <= 1'b0;
              if (is_write_reg) begin
                state_reg <= MERGE;
              end else begin
                state_reg     <= RESP;
                data_mem_resp <= 1'b1;
              end
            end
          end
        end
        MERGE: begin
          state_reg  <= WB_BURST;
          pmem_write <= 1'b1;
        end
        WB_BURST: begin
          if (pmem_resp) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (last_beat) begin
              pmem_write    <= 1'b0;
              state_reg     <= RESP;
              data_mem_resp <= 1'b1;
            end
          end
        end
        RESP: begin
          state_reg <= IDLE;
`ifdef LINE_BUF_EN
          valid_reg <= 1'b1;
          tag_reg   <= pmem_address[ADDR_W-1:OFF_W];
`endif
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
